// File: rtl/i2c_bus_arbiter_if.sv
// Signal bundle between the arbiter, its two internal IIC masters (S0/S1) and the external pads (M).
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
`timescale 1ns/1ps
interface i2c_bus_arbiter_if;
    logic       s0_scl_i, s0_sda_i, s0_scl_o, s0_scl_t, s0_sda_o, s0_sda_t;
    logic       s1_scl_i, s1_sda_i, s1_scl_o, s1_scl_t, s1_sda_o, s1_sda_t;
    logic       m_scl_i, m_sda_i, m_scl_o, m_scl_t, m_sda_o, m_sda_t;
    logic [1:0] grant;
    logic       bus_busy;

    modport slave (
        input  s0_scl_o, s0_scl_t, s0_sda_o, s0_sda_t,
        input  s1_scl_o, s1_scl_t, s1_sda_o, s1_sda_t,
        input  m_scl_i, m_sda_i,
        output s0_scl_i, s0_sda_i, s1_scl_i, s1_sda_i,
        output m_scl_o, m_scl_t, m_sda_o, m_sda_t,
        output grant, bus_busy
    );

    modport master (
        output s0_scl_o, s0_scl_t, s0_sda_o, s0_sda_t,
        output s1_scl_o, s1_scl_t, s1_sda_o, s1_sda_t,
        output m_scl_i, m_sda_i,
        input  s0_scl_i, s0_sda_i, s1_scl_i, s1_sda_i,
        input  m_scl_o, m_scl_t, m_sda_o, m_sda_t,
        input  grant, bus_busy
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Transaction-level arbiter sharing one external I2C bus between two internal masters.
// Optional stuck-owner watchdog and timeout_flag port enabled by defining I2C_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module i2c_bus_arbiter #(
    parameter int SYNC_STAGES     = 2,
    parameter int BUS_FREE_CYCLES = 64
`ifdef I2C_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 2_000_000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef I2C_ARB_TIMEOUT_EN
    output logic              timeout_flag,
`endif
    i2c_bus_arbiter_if.slave  bus
);
    localparam int HOLD_W = (BUS_FREE_CYCLES > 1) ? $clog2(BUS_FREE_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(BUS_FREE_CYCLES - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_OWN0, ST_OWN1, ST_EXT, ST_HOLD} state_t;

    state_t                   r_state;
    logic [1:0]               r_grant;
    logic                     r_busy;
    logic                     r_rr_s1;
    logic [HOLD_W-1:0]        r_hold_cnt;
    logic [SYNC_STAGES-1:0]   r_scl_sync, r_sda_sync;
    logic [SYNC_STAGES-1:0]   w_scl_next, w_sda_next;
    logic                     r_sda_d;
    logic                     w_scl_s, w_sda_s, w_start, w_stop;
    logic                     w_req0, w_req1, w_timeout;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_pad
                assign w_scl_next[gi] = bus.m_scl_i;
                assign w_sda_next[gi] = bus.m_sda_i;
            end else begin : g_chain
                assign w_scl_next[gi] = r_scl_sync[gi-1];
                assign w_sda_next[gi] = r_sda_sync[gi-1];
            end
        end
    endgenerate

    // Idle-high reset keeps the first cycles from looking like a START/STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= w_scl_next;
            r_sda_sync <= w_sda_next;
            r_sda_d    <= w_sda_s;
        end
    end

    assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s = r_sda_sync[SYNC_STAGES-1];
    assign w_start = r_sda_d & ~w_sda_s & w_scl_s;
    assign w_stop  = ~r_sda_d & w_sda_s & w_scl_s;
    assign w_req0  = ~bus.s0_sda_t & ~bus.s0_sda_o;
    assign w_req1  = ~bus.s1_sda_t & ~bus.s1_sda_o;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic            r_scl_d;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_flag;
    logic            w_bus_edge, w_watch;

    assign w_bus_edge = (w_scl_s != r_scl_d) || (w_sda_s != r_sda_d);
    assign w_watch    = (r_state == ST_OWN0) || (r_state == ST_OWN1) || (r_state == ST_EXT);
    assign w_timeout  = w_watch && w_scl_s && !w_bus_edge && (r_to_cnt == TO_LAST);

    // Counts only while SCL sits high with no line activity: a frozen owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_d        <= 1'b1;
            r_to_cnt       <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_scl_d <= w_scl_s;
            if (!w_watch || w_bus_edge || w_timeout)
                r_to_cnt <= '0;
            else if (w_scl_s)
                r_to_cnt <= r_to_cnt + TO_W'(1);
            if (w_timeout)
                r_timeout_flag <= 1'b1;
        end
    end

    assign timeout_flag = r_timeout_flag;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= 2'b00;
            r_busy     <= 1'b0;
            r_rr_s1    <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start && !w_req0 && !w_req1) begin
                        r_state <= ST_EXT;
                        r_busy  <= 1'b1;
                    end else if (w_req0 && (!w_req1 || !r_rr_s1)) begin
                        r_state <= ST_OWN0;
                        r_grant <= 2'b01;
                        r_busy  <= 1'b1;
                        r_rr_s1 <= 1'b1;
                    end else if (w_req1) begin
                        r_state <= ST_OWN1;
                        r_grant <= 2'b10;
                        r_busy  <= 1'b1;
                        r_rr_s1 <= 1'b0;
                    end
                end
                ST_OWN0, ST_OWN1, ST_EXT: begin
                    if (w_stop || w_timeout) begin
                        r_state    <= ST_HOLD;
                        r_hold_cnt <= HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    // Grant is kept through tBUF so the owner cannot be re-arbitrated early.
                    if (w_start) begin
                        r_state    <= ST_EXT;
                        r_grant    <= 2'b00;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_grant <= 2'b00;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.m_scl_o  = 1'b1;
        bus.m_scl_t  = 1'b1;
        bus.m_sda_o  = 1'b1;
        bus.m_sda_t  = 1'b1;
        bus.s0_scl_i = 1'b0;
        bus.s1_scl_i = 1'b0;
        bus.s0_sda_i = bus.m_sda_i;
        bus.s1_sda_i = bus.m_sda_i;
        case (r_state)
            ST_IDLE: begin
                bus.s0_scl_i = bus.m_scl_i;
                bus.s1_scl_i = bus.m_scl_i;
            end
            ST_OWN0: begin
                bus.m_scl_o  = bus.s0_scl_o;
                bus.m_scl_t  = bus.s0_scl_t;
                bus.m_sda_o  = bus.s0_sda_o;
                bus.m_sda_t  = bus.s0_sda_t;
                bus.s0_scl_i = bus.m_scl_i;
            end
            ST_OWN1: begin
                bus.m_scl_o  = bus.s1_scl_o;
                bus.m_scl_t  = bus.s1_scl_t;
                bus.m_sda_o  = bus.s1_sda_o;
                bus.m_sda_t  = bus.s1_sda_t;
                bus.s1_scl_i = bus.m_scl_i;
            end
            default: begin
            end
        endcase
    end

    assign bus.grant    = r_grant;
    assign bus.bus_busy = r_busy;
endmodule
